mem_access_stage: RTL and testbench

- Memory stage of the 5-stage RISC-V pipeline. It consumes the EX/MEM pipeline register outputs.
- Resolves branches and generates PCSrc and the upstream flush.
- Runs the data-memory request/grant/response handshake and produces the stall that freezes earlier stages.
- Registers results into the MEM/WB fields.

---
 rtl/mem_access_stage_if.sv | 23 ++
 rtl/mem_access_stage.sv | 213 +++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory request/grant/response bus between the MEM stage and the data memory.
interface mem_access_stage_if #(
  parameter int XLEN = 64
);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [1:0]      mem_size;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_size, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_size, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// RISC-V MEM stage: branch resolution, data-memory handshake with timeout abort,
// pipeline stall generation and the MEM/WB pipeline register.
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int XLEN    = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               RegWrite_store,
  input  logic               MemtoReg_store,
  input  logic               Branch_store,
  input  logic               Zero_store,
  input  logic               MemWrite_store,
  input  logic               MemRead_store,
  input  logic               Is_Greater_store,
  input  logic [XLEN-1:0]    PCplusimm_store,
  input  logic [XLEN-1:0]    ALU_result_store,
  input  logic [XLEN-1:0]    WriteData_store,
  input  logic [3:0]         funct_in_store,
  input  logic [4:0]         rd_store,
  mem_access_stage_if.master mem,
  output logic               PCSrc,
  output logic [XLEN-1:0]    BranchTarget,
  output logic               Flush_out,
  output logic               Stall,
  output logic               bus_error,
  output logic               RegWrite_wb,
  output logic               MemtoReg_wb,
  output logic [XLEN-1:0]    ReadData_wb,
  output logic [XLEN-1:0]    ALU_result_wb,
  output logic [4:0]         rd_wb
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST_C = 8'(TIMEOUT - 1);

  state_t     state_r;
  state_t     state_nx_s;
  logic [7:0] tmo_cnt_r;
  logic       bus_error_r;
  logic [2:0] funct3_s;
  logic       acc_s;
  logic       taken_s;
  logic       req_s;
  logic       complete_s;
  logic       abort_s;
  logic       load_done_s;
  logic       tmo_hit_s;
  logic       stall_s;
  logic       unused_s;

  // Right-aligned load data extended to XLEN according to size and signedness.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] d, input logic [2:0] f3);
    logic [XLEN-1:0] v;
    case (f3[1:0])
      2'b00:   v = f3[2] ? {{(XLEN-8){1'b0}}, d[7:0]}   : {{(XLEN-8){d[7]}}, d[7:0]};
      2'b01:   v = f3[2] ? {{(XLEN-16){1'b0}}, d[15:0]} : {{(XLEN-16){d[15]}}, d[15:0]};
      2'b10:   v = f3[2] ? {{(XLEN-32){1'b0}}, d[31:0]} : {{(XLEN-32){d[31]}}, d[31:0]};
      default: v = d;
    endcase
    return v;
  endfunction

  assign funct3_s = funct_in_store[2:0];
  assign acc_s    = MemRead_store | MemWrite_store;
  assign unused_s = funct_in_store[3];

  // Branch condition from funct3 and the ALU flags.
  always_comb begin
    taken_s = 1'b0;
    case (funct3_s)
      3'b000:  taken_s = Zero_store;
      3'b001:  taken_s = ~Zero_store;
      3'b100:  taken_s = ~Is_Greater_store & ~Zero_store;
      3'b101:  taken_s = Is_Greater_store | Zero_store;
      default: taken_s = 1'b0;
    endcase
  end

  // Handshake FSM: next state, Mealy request and completion/abort events.
  always_comb begin
    state_nx_s  = state_r;
    req_s       = 1'b0;
    complete_s  = 1'b0;
    abort_s     = 1'b0;
    load_done_s = 1'b0;
    tmo_hit_s   = (tmo_cnt_r == TMO_LAST_C);
    case (state_r)
      IDLE: begin
        if (acc_s) begin
          req_s = 1'b1;
          if (mem.mem_gnt) begin
            if (MemRead_store) begin
              state_nx_s = WAIT;
            end else begin
              complete_s = 1'b1;
            end
          end else begin
            state_nx_s = REQ;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      REQ: begin
        if (mem.mem_gnt) begin
          req_s = 1'b1;
          if (MemRead_store) begin
            state_nx_s = WAIT;
          end else begin
            complete_s = 1'b1;
            state_nx_s = IDLE;
          end
        end else if (tmo_hit_s) begin
          abort_s    = 1'b1;
          complete_s = 1'b1;
          state_nx_s = IDLE;
        end else begin
          req_s = 1'b1;
        end
      end
      WAIT: begin
        if (mem.mem_rvalid) begin
          complete_s  = 1'b1;
          load_done_s = 1'b1;
          state_nx_s  = IDLE;
        end else if (tmo_hit_s) begin
          abort_s    = 1'b1;
          complete_s = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = WAIT;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Combinational outputs are gated by reset so they drop as soon as it asserts.
  assign stall_s        = reset_n & acc_s & ~complete_s;
  assign Stall          = stall_s;
  assign PCSrc          = reset_n & Branch_store & taken_s;
  assign Flush_out      = reset_n & Branch_store & taken_s;
  assign BranchTarget   = PCplusimm_store;
  assign bus_error      = bus_error_r;
  assign mem.mem_req    = reset_n & req_s;
  assign mem.mem_we     = MemWrite_store & ~MemRead_store;
  assign mem.mem_addr   = ALU_result_store;
  assign mem.mem_size   = funct3_s[1:0];
  assign mem.mem_wdata  = WriteData_store;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Timeout counter restarts on every state change and counts REQ/WAIT cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_r <= 8'd0;
    end else if (state_nx_s != state_r) begin
      tmo_cnt_r <= 8'd0;
    end else if (state_r != IDLE) begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end else begin
      tmo_cnt_r <= 8'd0;
    end
  end

  // Sticky bus error, set by any timeout abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_error_r <= 1'b0;
    end else if (abort_s) begin
      bus_error_r <= 1'b1;
    end else begin
      bus_error_r <= bus_error_r;
    end
  end

  // MEM/WB register: bubble while stalled, aborted accesses retire without a write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      RegWrite_wb   <= 1'b0;
      MemtoReg_wb   <= 1'b0;
      ReadData_wb   <= '0;
      ALU_result_wb <= '0;
      rd_wb         <= 5'd0;
    end else if (stall_s) begin
      RegWrite_wb <= 1'b0;
    end else begin
      RegWrite_wb   <= RegWrite_store & ~abort_s;
      MemtoReg_wb   <= MemtoReg_store & ~abort_s;
      ALU_result_wb <= ALU_result_store;
      rd_wb         <= rd_store;
      if (load_done_s) begin
        ReadData_wb <= load_ext(mem.mem_rdata, funct3_s);
      end else begin
        ReadData_wb <= ReadData_wb;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized scoreboard bench for mem_access_stage against a cycle-count reference model.
module tb_mem_access_stage;
  localparam int XLEN = 64;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic reset_n;
  logic rw_i, m2r_i, br_i, zero_i, mw_i, mr_i, isg_i;
  logic [XLEN-1:0] pci_i, alu_i, wd_i;
  logic [3:0] f4_i;
  logic [4:0] rd_i;
  logic PCSrc, Flush_out, Stall, bus_error, RegWrite_wb, MemtoReg_wb;
  logic [XLEN-1:0] BranchTarget, ReadData_wb, ALU_result_wb;
  logic [4:0] rd_wb;

  mem_access_stage_if #(.XLEN(XLEN)) mif ();

  mem_access_stage #(.TIMEOUT(TMO), .XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n),
    .RegWrite_store(rw_i), .MemtoReg_store(m2r_i), .Branch_store(br_i), .Zero_store(zero_i),
    .MemWrite_store(mw_i), .MemRead_store(mr_i), .Is_Greater_store(isg_i),
    .PCplusimm_store(pci_i), .ALU_result_store(alu_i), .WriteData_store(wd_i),
    .funct_in_store(f4_i), .rd_store(rd_i), .mem(mif),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget), .Flush_out(Flush_out), .Stall(Stall),
    .bus_error(bus_error), .RegWrite_wb(RegWrite_wb), .MemtoReg_wb(MemtoReg_wb),
    .ReadData_wb(ReadData_wb), .ALU_result_wb(ALU_result_wb), .rd_wb(rd_wb)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              stall;
    logic            rw;
    logic            m2r;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] alu;
    logic [4:0]      rd;
    logic            berr;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  logic [XLEN-1:0] model_rdata = '0;
  bit model_berr = 1'b0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Loaded value as the architecture defines it: take the low bytes, then sign-extend arithmetically.
  function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] d, input logic [2:0] f3);
    int nbits;
    logic [XLEN-1:0] v;
    nbits = 8 << f3[1:0];
    if (nbits >= XLEN) return d;
    v = d & ((64'd1 << nbits) - 64'd1);
    if (!f3[2] && v[nbits-1]) v = v - (64'd1 << nbits);
    return v;
  endfunction

  task automatic set_idle();
    {rw_i, m2r_i, br_i, zero_i, mw_i, mr_i, isg_i} = 7'd0;
    pci_i = '0; alu_i = '0; wd_i = '0; f4_i = 4'd0; rd_i = 5'd0;
    mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = '0;
  endtask

  // Present one instruction; g = cycle of grant, r = cycles from grant to rvalid.
  task automatic issue(input logic rw, m2r, br, zero, mw, mr, isg,
                       input logic [XLEN-1:0] pci, alu, wd, input logic [3:0] f4,
                       input logic [4:0] rd, input int g, input int r, input logic [XLEN-1:0] rdat);
    bit acc, abort, tk, exp_req;
    int done;
    exp_t e;
    logic [2:0] f3;
    acc = mr | mw;
    f3  = f4[2:0];
    abort = 1'b0;
    if (!acc)          done = 0;
    else if (g > TMO)  begin done = TMO;     abort = 1'b1; end
    else if (!mr)      done = g;
    else if (r > TMO)  begin done = g + TMO; abort = 1'b1; end
    else               done = g + r;
    if (acc && mr && !abort) model_rdata = ext(rdat, f3);
    if (abort) model_berr = 1'b1;
    e.stall = done; e.rw = abort ? 1'b0 : rw; e.m2r = abort ? 1'b0 : m2r;
    e.rdata = model_rdata; e.alu = alu; e.rd = rd; e.berr = model_berr;
    exp_q.push_back(e);
    case (f3)
      3'd0:    tk = zero;
      3'd1:    tk = !zero;
      3'd4:    tk = !isg && !zero;
      3'd5:    tk = isg || zero;
      default: tk = 1'b0;
    endcase
    tk = tk && br;
    rw_i = rw; m2r_i = m2r; br_i = br; zero_i = zero; mw_i = mw; mr_i = mr; isg_i = isg;
    pci_i = pci; alu_i = alu; wd_i = wd; f4_i = f4; rd_i = rd;
    for (int c = 0; c <= done; c++) begin
      mif.mem_gnt    = acc && (c == g);
      mif.mem_rvalid = (acc && mr && (c == g + r)) || ((c <= g) && ($urandom_range(0, 1) == 1));
      mif.mem_rdata  = (c == g + r) ? rdat : {$urandom, $urandom};
      #2;
      exp_req = acc && ((g <= TMO) ? (c <= g) : (c < TMO));
      chk("mem_req", mif.mem_req, exp_req);
      if (c == 0) begin
        chk("PCSrc", PCSrc, tk);
        chk("Flush_out", Flush_out, tk);
        chk("BranchTarget", BranchTarget, pci);
        if (acc) begin
          chk("mem_we", mif.mem_we, mw && !mr);
          chk("mem_size", mif.mem_size, f3[1:0]);
          chk("mem_addr", mif.mem_addr, alu);
          chk("mem_wdata", mif.mem_wdata, wd);
        end
      end
      @(posedge clk);
      #1;
    end
    mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0;
  endtask

  task automatic rand_instr(input bit allow_tmo);
    logic rw, m2r, br, zero, mw, mr, isg;
    logic [2:0] f3;
    int g, r;
    {rw, m2r, br, mw, mr} = 5'd0;
    zero = 1'($urandom_range(0, 1)); isg = 1'($urandom_range(0, 1));
    f3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0: rw = 1'b1;
      1: begin mr = 1'b1; rw = 1'b1; m2r = 1'b1; mw = 1'($urandom_range(0, 3) == 0);
               f3 = 3'($urandom_range(0, 6)); end
      2: begin mw = 1'b1; f3 = 3'($urandom_range(0, 3)); end
      default: br = 1'b1;
    endcase
    g = (allow_tmo && $urandom_range(0, 5) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 3);
    r = (allow_tmo && $urandom_range(0, 5) == 0) ? $urandom_range(14, 18) : $urandom_range(1, 4);
    issue(rw, m2r, br, zero, mw, mr, isg, {$urandom, $urandom}, {$urandom, $urandom},
          {$urandom, $urandom}, {1'($urandom_range(0, 1)), f3}, 5'($urandom_range(0, 31)),
          g, r, {$urandom, $urandom});
  endtask

  task automatic drain();
    set_idle();
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: each Stall-free cycle retires one instruction; its MEM/WB result is visible one edge later.
  bit pending = 1'b0;
  int stall_cnt = 0;
  int done_stall = 0;
  exp_t me;
  always @(negedge clk) begin
    if (!mon_en) begin
      pending = 1'b0; stall_cnt = 0;
    end else begin
      if (pending) begin
        pending = 1'b0;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL wb_unexpected: retirement with empty queue at %0t", $time);
        end else begin
          me = exp_q.pop_front();
          chk("stall_cycles", 64'(done_stall), 64'(me.stall));
          chk("RegWrite_wb", RegWrite_wb, me.rw);
          chk("MemtoReg_wb", MemtoReg_wb, me.m2r);
          chk("ReadData_wb", ReadData_wb, me.rdata);
          chk("ALU_result_wb", ALU_result_wb, me.alu);
          chk("rd_wb", rd_wb, me.rd);
          chk("bus_error", bus_error, me.berr);
        end
      end
      if (Stall) stall_cnt++;
      else begin done_stall = stall_cnt; stall_cnt = 0; pending = 1'b1; end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    set_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_Stall", Stall, 1'b0);
    chk("rst_mem_req", mif.mem_req, 1'b0);
    chk("rst_bus_error", bus_error, 1'b0);
    chk("rst_RegWrite_wb", RegWrite_wb, 1'b0);
    chk("rst_ReadData_wb", ReadData_wb, '0);
    chk("rst_ALU_result_wb", ALU_result_wb, '0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // add, sd zero-wait, lb/lbu with latency, beq taken, bge not taken
    issue(1, 0, 0, 0, 0, 0, 0, 64'h0, 64'd42, 64'h0, 4'h0, 5'd5, 0, 1, 64'h0);
    issue(0, 0, 0, 0, 1, 0, 0, 64'h0, 64'h100, 64'hDEADBEEF_CAFEF00D, 4'h3, 5'd0, 0, 1, 64'h0);
    issue(1, 1, 0, 0, 0, 1, 0, 64'h0, 64'h20, 64'h0, 4'h0, 5'd7, 2, 3, 64'h80);
    issue(1, 1, 0, 0, 0, 1, 0, 64'h0, 64'h20, 64'h0, 4'h4, 5'd8, 2, 3, 64'h80);
    issue(0, 0, 1, 1, 0, 0, 0, 64'h400, 64'h0, 64'h0, 4'h0, 5'd0, 0, 1, 64'h0);
    issue(0, 0, 1, 0, 0, 0, 0, 64'h400, 64'h0, 64'h0, 4'h5, 5'd0, 0, 1, 64'h0);
    for (int i = 0; i < 60; i++) rand_instr(1'b0);

    // lw never granted: abort after TIMEOUT stall cycles, then an add without stall
    issue(1, 1, 0, 0, 0, 1, 0, 64'h0, 64'h80, 64'h0, 4'h2, 5'd9, 1000, 1, 64'h0);
    issue(1, 0, 0, 0, 0, 0, 0, 64'h0, 64'd77, 64'h0, 4'h0, 5'd3, 0, 1, 64'h0);
    for (int i = 0; i < 40; i++) rand_instr(1'b1);
    drain();

    // reset asserted while a lw is waiting for its response
    rw_i = 1'b1; m2r_i = 1'b1; mr_i = 1'b1; f4_i = 4'h2; alu_i = 64'h40; rd_i = 5'd4;
    mif.mem_gnt = 1'b1;
    @(posedge clk);
    #1;
    mif.mem_gnt = 1'b0;
    @(posedge clk);
    #1;
    chk("wait_Stall", Stall, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_Stall", Stall, 1'b0);
    chk("async_mem_req", mif.mem_req, 1'b0);
    chk("async_bus_error", bus_error, 1'b0);
    chk("async_RegWrite_wb", RegWrite_wb, 1'b0);
    chk("async_MemtoReg_wb", MemtoReg_wb, 1'b0);
    chk("async_ReadData_wb", ReadData_wb, '0);
    chk("async_ALU_result_wb", ALU_result_wb, '0);
    chk("async_rd_wb", rd_wb, 5'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mif.mem_rvalid = 1'b1;
    mif.mem_rdata = 64'h1234_5678_9ABC_DEF0;
    @(posedge clk);
    #1;
    chk("late_rvalid_ReadData_wb", ReadData_wb, '0);
    chk("late_rvalid_Stall", Stall, 1'b1);
    set_idle();
    reset_n = 1'b0;
    #20;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
